// File: rtl/ap_parameters_pkg.sv
// Shared parameters and state encoding for the feature normalizer.
package ap_parameters;

  localparam int NORM_DATA_W    = 16;
  localparam int NORM_OUT_W     = 16;
  localparam int NORM_N_COEF    = 32;
  localparam int NORM_FRAC_BITS = 8;

  typedef enum logic [1:0] {
    NORM_IDLE,
    NORM_WAIT_MS,
    NORM_DIV,
    NORM_OUT
  } norm_state_t;

endpackage

// File: rtl/feature_normalizer_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, W cycles per divide.
module seq_divider #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [W-1:0] w_rem_src;
  logic [W-1:0] w_quo_src;
  logic [W:0]   w_shift;
  logic         w_ge;
  logic [W-1:0] w_rem_nxt;
  logic [W-1:0] w_quo_nxt;

  // The start cycle already performs the first step on the fresh dividend.
  always_comb begin
    w_rem_src = i_start ? '0 : r_rem;
    w_quo_src = i_start ? i_dividend : r_quo;
    w_shift   = {w_rem_src, w_quo_src[W-1]};
    w_ge      = (w_shift >= {1'b0, i_divisor});
    w_rem_nxt = w_ge ? (w_shift[W-1:0] - i_divisor) : w_shift[W-1:0];
    w_quo_nxt = {w_quo_src[W-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_cnt  <= CNT_W'(W - 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_cnt  <= r_cnt - CNT_W'(1);
      r_busy <= (r_cnt != CNT_W'(1));
      r_done <= (r_cnt == CNT_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/feature_normalizer.sv
// Z-score normalizer: latches a mel frame, waits for its mean/std, streams (x-mean)/std.
// Define FEATURE_NORM_SAT_EN to clamp out-of-range results instead of wrapping them.
module feature_normalizer
  import ap_parameters::*;
#(
  parameter int DATA_W    = NORM_DATA_W,
  parameter int OUT_W     = NORM_OUT_W,
  parameter int N_COEF    = NORM_N_COEF,
  parameter int FRAC_BITS = NORM_FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_frame_valid,
  input  logic [N_COEF-1:0][DATA_W-1:0]  i_frame_data,
  output logic                           o_frame_ready,
  input  logic                           i_ms_valid,
  input  logic [DATA_W-1:0]              i_mean,
  input  logic [DATA_W-1:0]              i_std,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [OUT_W-1:0]               o_out_data,
  output logic [$clog2(N_COEF)-1:0]      o_out_idx,
  output logic                           o_out_last
);

  localparam int Q_W   = DATA_W + FRAC_BITS;
  localparam int IDX_W = $clog2(N_COEF);

  norm_state_t r_state;
  norm_state_t w_next_state;

  logic [N_COEF-1:0][DATA_W-1:0] r_frame;
  logic [DATA_W-1:0]             r_mean;
  logic [DATA_W-1:0]             r_std;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_div_pend;
  logic                          r_neg;
  logic [OUT_W-1:0]              r_out_data;
  logic [IDX_W-1:0]              r_out_idx;
  logic                          r_out_last;

  logic                     w_frame_acc;
  logic                     w_ms_acc;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_start;
  logic [IDX_W-1:0]         w_div_idx;
  logic signed [DATA_W:0]   w_diff;
  logic signed [DATA_W:0]   w_neg_diff;
  logic [DATA_W-1:0]        w_abs;
  logic [Q_W-1:0]           w_dividend;
  logic [Q_W-1:0]           w_divisor;
  logic [Q_W-1:0]           w_quo;
  logic                     w_div_done;
  logic                     w_unused_div_busy;
  logic signed [Q_W:0]      w_quo_ext;
  logic signed [Q_W:0]      w_signed;
  logic [OUT_W-1:0]         w_result;

  always_ff @(posedge clk) begin
    if (rst) r_state <= NORM_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_frame_acc   = 1'b0;
    w_ms_acc      = 1'b0;
    w_hs          = 1'b0;
    o_frame_ready = (r_state == NORM_IDLE);
    o_out_valid   = (r_state == NORM_OUT);
    case (r_state)
      NORM_IDLE: begin
        if (i_frame_valid) begin
          w_frame_acc  = 1'b1;
          w_next_state = NORM_WAIT_MS;
        end
      end
      NORM_WAIT_MS: begin
        if (i_ms_valid) begin
          w_ms_acc     = 1'b1;
          w_next_state = NORM_DIV;
        end
      end
      NORM_DIV: begin
        if (w_div_done) w_next_state = NORM_OUT;
      end
      NORM_OUT: begin
        if (i_out_ready) begin
          w_hs         = 1'b1;
          w_next_state = w_last ? NORM_IDLE : NORM_DIV;
        end
      end
      default: w_next_state = NORM_IDLE;
    endcase
  end

  // A handshake launches the next coefficient's divide in the same edge, hence idx+1 here.
  assign w_last     = (r_idx == IDX_W'(N_COEF - 1));
  assign w_start    = r_div_pend | (w_hs & ~w_last);
  assign w_div_idx  = w_hs ? (r_idx + IDX_W'(1)) : r_idx;
  assign w_diff     = $signed({1'b0, r_frame[w_div_idx]}) - $signed({1'b0, r_mean});
  assign w_neg_diff = -w_diff;
  assign w_abs      = w_diff[DATA_W] ? w_neg_diff[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_dividend = {w_abs, {FRAC_BITS{1'b0}}};
  assign w_divisor  = {{FRAC_BITS{1'b0}}, r_std};
  assign w_quo_ext  = $signed({1'b0, w_quo});
  assign w_signed   = r_neg ? -w_quo_ext : w_quo_ext;

  seq_divider #(
    .W (Q_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_unused_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

`ifdef FEATURE_NORM_SAT_EN
  localparam logic signed [Q_W:0] MAX_V = {{(Q_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [Q_W:0] MIN_V = {{(Q_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    w_result = w_signed[OUT_W-1:0];
    if (w_signed > MAX_V)      w_result = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_signed < MIN_V) w_result = {1'b1, {(OUT_W-1){1'b0}}};
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_signed[Q_W:OUT_W];
  assign w_result    = w_signed[OUT_W-1:0];
`endif

  // Zero std would make the divide meaningless; treat it as unit std.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame    <= '0;
      r_mean     <= '0;
      r_std      <= '0;
      r_idx      <= '0;
      r_div_pend <= 1'b0;
      r_neg      <= 1'b0;
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_div_pend <= w_ms_acc;
      if (w_frame_acc) r_frame <= i_frame_data;
      if (w_ms_acc) begin
        r_mean <= i_mean;
        r_std  <= (i_std == '0) ? DATA_W'(1) : i_std;
        r_idx  <= '0;
      end
      if (w_hs)    r_idx <= r_idx + IDX_W'(1);
      if (w_start) r_neg <= w_diff[DATA_W];
      if ((r_state == NORM_DIV) && w_div_done) begin
        r_out_data <= w_result;
        r_out_idx  <= r_idx;
        r_out_last <= w_last;
      end
    end
  end

  assign o_out_data = r_out_data;
  assign o_out_idx  = r_out_idx;
  assign o_out_last = r_out_last;

endmodule

// File: tb/tb_feature_normalizer.sv
// Directed, table-driven bench for feature_normalizer (both FEATURE_NORM_SAT_EN builds).
module tb_feature_normalizer;

  localparam int DATA_W    = 16;
  localparam int OUT_W     = 16;
  localparam int N_COEF    = 32;
  localparam int FRAC_BITS = 8;
  localparam int Q_W       = DATA_W + FRAC_BITS;
  localparam int IDX_W     = $clog2(N_COEF);
  localparam int WAIT_MAX  = 200;
`ifdef FEATURE_NORM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] mean;
    logic [15:0] sd;
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  logic                          clk;
  logic                          rst;
  logic                          frameValid;
  logic [N_COEF-1:0][DATA_W-1:0] frameData;
  logic                          frameReady;
  logic                          msValid;
  logic [DATA_W-1:0]             mean;
  logic [DATA_W-1:0]             stdDev;
  logic                          outValid;
  logic                          outReady;
  logic [OUT_W-1:0]              outData;
  logic [IDX_W-1:0]              outIdx;
  logic                          outLast;

  int nChecks = 0;
  int nErrors = 0;
  vec_t vecs[8];

  feature_normalizer #(
    .DATA_W    (DATA_W),
    .OUT_W     (OUT_W),
    .N_COEF    (N_COEF),
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_valid (frameValid),
    .i_frame_data  (frameData),
    .o_frame_ready (frameReady),
    .i_ms_valid    (msValid),
    .i_mean        (mean),
    .i_std         (stdDev),
    .o_out_valid   (outValid),
    .i_out_ready   (outReady),
    .o_out_data    (outData),
    .o_out_idx     (outIdx),
    .o_out_last    (outLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!outValid && lat < WAIT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!outValid) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL waitValid: out_valid=0 after %0d cycles, expected 1", lat);
    end
  endtask

  // Loads a frame then pulses mean/std; returns just after the capture edge.
  task automatic applyStimulus(input logic [N_COEF-1:0][DATA_W-1:0] f,
                               input logic [15:0] m, input logic [15:0] s);
    int n;
    n = 0;
    while (!frameReady && n < WAIT_MAX) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("frameReadyBeforeLoad", frameReady, 1);
    frameValid = 1'b1;
    frameData  = f;
    @(posedge clk); #1;
    frameValid = 1'b0;
    msValid    = 1'b1;
    mean       = m;
    stdDev     = s;
    @(posedge clk); #1;
    msValid    = 1'b0;
  endtask

  task automatic drainFrame(input int fromIdx);
    int lat;
    for (int k = fromIdx; k < N_COEF; k++) begin
      waitValid(lat);
      checkOutput($sformatf("drainIdx[%0d]", k), outIdx, k);
      @(posedge clk); #1;
    end
    checkOutput("drainFrameReady", frameReady, 1);
  endtask

  task automatic runFrame(input int vi, input vec_t v);
    logic [N_COEF-1:0][DATA_W-1:0] f;
    int lat;
    for (int i = 0; i < N_COEF; i++) f[i] = (i == 1) ? v.x1 : v.x0;
    outReady = 1'b1;
    applyStimulus(f, v.mean, v.sd);
    for (int k = 0; k < N_COEF; k++) begin
      waitValid(lat);
      checkOutput($sformatf("v%0d latency[%0d]", vi, k), lat, (k == 0) ? Q_W + 1 : Q_W);
      checkOutput($sformatf("v%0d data[%0d]", vi, k), outData, (k == 1) ? v.exp1 : v.exp0);
      checkOutput($sformatf("v%0d idx[%0d]", vi, k), outIdx, k);
      checkOutput($sformatf("v%0d last[%0d]", vi, k), outLast, (k == N_COEF - 1));
      @(posedge clk); #1;
    end
    checkOutput($sformatf("v%0d readyAfterLast", vi), frameReady, 1);
    checkOutput($sformatf("v%0d validAfterLast", vi), outValid, 0);
    repeat (Q_W + 4) @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d noExtraOutput", vi), outValid, 0);
  endtask

  initial begin
    logic [N_COEF-1:0][DATA_W-1:0] f;
    int lat;

    vecs[0] = '{mean: 16'd100,   sd: 16'd10,    x0: 16'd120,   x1: 16'd80,
                exp0: 16'h0200,  exp1: 16'hFE00};
    vecs[1] = '{mean: 16'd50,    sd: 16'd0,     x0: 16'd50,    x1: 16'd51,
                exp0: 16'h0000,  exp1: 16'h0100};
    vecs[2] = '{mean: 16'd0,     sd: 16'd1,     x0: 16'hFFFF,  x1: 16'd0,
                exp0: SAT_EN ? 16'h7FFF : 16'hFF00, exp1: 16'h0000};
    vecs[3] = '{mean: 16'hFFFF,  sd: 16'd1,     x0: 16'd0,     x1: 16'hFFFF,
                exp0: SAT_EN ? 16'h8000 : 16'h0100, exp1: 16'h0000};
    vecs[4] = '{mean: 16'd10,    sd: 16'd3,     x0: 16'd11,    x1: 16'd9,
                exp0: 16'h0055,  exp1: 16'hFFAB};
    vecs[5] = '{mean: 16'd1000,  sd: 16'd60000, x0: 16'd999,   x1: 16'd1000,
                exp0: 16'h0000,  exp1: 16'h0000};
    vecs[6] = '{mean: 16'h8000,  sd: 16'h0100,  x0: 16'hFFFF,  x1: 16'd0,
                exp0: 16'h7FFF,  exp1: 16'h8000};
    vecs[7] = '{mean: 16'd0,     sd: 16'h0100,  x0: 16'h8000,  x1: 16'd0,
                exp0: SAT_EN ? 16'h7FFF : 16'h8000, exp1: 16'h0000};

    rst        = 1'b1;
    frameValid = 1'b0;
    frameData  = '0;
    msValid    = 1'b0;
    mean       = '0;
    stdDev     = '0;
    outReady   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("resetFrameReady", frameReady, 1);
    checkOutput("resetOutValid", outValid, 0);
    checkOutput("resetOutData", outData, 0);
    checkOutput("resetOutIdx", outIdx, 0);
    checkOutput("resetOutLast", outLast, 0);

    $display("[TB] table vectors");
    for (int v = 0; v < 8; v++) runFrame(v, vecs[v]);

    $display("[TB] out_ready stall");
    for (int i = 0; i < N_COEF; i++) f[i] = 16'd100;
    f[0] = 16'd120;
    f[1] = 16'd80;
    outReady = 1'b0;
    applyStimulus(f, 16'd100, 16'd10);
    waitValid(lat);
    checkOutput("stallFirstLatency", lat, Q_W + 1);
    checkOutput("stallFirstData", outData, 16'h0200);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stallValid[%0d]", c), outValid, 1);
      checkOutput($sformatf("stallData[%0d]", c), outData, 16'h0200);
      checkOutput($sformatf("stallIdx[%0d]", c), outIdx, 0);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("stallValidAfterHs", outValid, 0);
    waitValid(lat);
    checkOutput("stallHsLatency", lat, Q_W);
    checkOutput("stallSecondData", outData, 16'hFE00);
    checkOutput("stallSecondIdx", outIdx, 1);
    @(posedge clk); #1;
    drainFrame(2);

    $display("[TB] ignored frame_valid and ms_valid");
    outReady = 1'b0;
    msValid  = 1'b1;
    mean     = 16'd0;
    stdDev   = 16'd1;
    @(posedge clk); #1;
    msValid  = 1'b0;
    checkOutput("idleMsIgnored", frameReady, 1);
    frameValid = 1'b1;
    frameData  = f;
    msValid    = 1'b1;
    @(posedge clk); #1;
    frameValid = 1'b0;
    msValid    = 1'b0;
    checkOutput("waitMsFrameReady", frameReady, 0);
    frameValid = 1'b1;
    frameData  = '0;
    @(posedge clk); #1;
    frameValid = 1'b0;
    repeat (Q_W + 5) @(posedge clk);
    #1;
    checkOutput("noOutputWithoutMs", outValid, 0);
    checkOutput("stillWaitingMs", frameReady, 0);
    msValid = 1'b1;
    mean    = 16'd100;
    stdDev  = 16'd10;
    @(posedge clk); #1;
    msValid  = 1'b0;
    outReady = 1'b1;
    waitValid(lat);
    checkOutput("ignoreLatency", lat, Q_W + 1);
    checkOutput("ignoreData0", outData, 16'h0200);
    checkOutput("ignoreIdx0", outIdx, 0);
    @(posedge clk); #1;
    waitValid(lat);
    checkOutput("ignoreData1", outData, 16'hFE00);
    checkOutput("ignoreIdx1", outIdx, 1);
    @(posedge clk); #1;
    drainFrame(2);

    $display("[TB] reset during divide");
    for (int i = 0; i < N_COEF; i++) f[i] = 16'(100 + 10 * i);
    outReady = 1'b1;
    applyStimulus(f, 16'd100, 16'd10);
    for (int k = 0; k < 3; k++) begin
      waitValid(lat);
      checkOutput($sformatf("preResetData[%0d]", k), outData, 16'(k * 256));
      checkOutput($sformatf("preResetIdx[%0d]", k), outIdx, k);
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midDivNoValid", outValid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("postResetValid", outValid, 0);
    checkOutput("postResetFrameReady", frameReady, 1);
    checkOutput("postResetData", outData, 0);
    checkOutput("postResetIdx", outIdx, 0);
    repeat (Q_W + 4) @(posedge clk);
    #1;
    checkOutput("partialDivDiscarded", outValid, 0);
    runFrame(8, vecs[0]);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
